// File: rtl/audio_adc_i2s_receiver.sv
// ============================================================================
// Module   : audio_adc_i2s_receiver
// Brief    : Codec ADC serial-audio receiver (I2S or left-justified framing)
//            that buffers complete stereo pairs in a FIFO behind valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_adc_i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int I2S_MODE   = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  adc_bclk,
  input  logic                  adc_lrck,
  input  logic                  adc_dat,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overflow,
  output logic                  frame_error,
  input  logic                  clear_status
);

  localparam int c_cnt_w  = $clog2(DATA_WIDTH);
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w  = $clog2(FIFO_DEPTH + 1);
  localparam int c_pair_w = 2 * DATA_WIDTH;

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(FIFO_DEPTH);
  localparam logic               c_i2s      = (I2S_MODE != 0);
  localparam logic               c_left_lvl = (I2S_MODE != 0) ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_SKIP_L  = 3'd1,
    ST_SHIFT_L = 3'd2,
    ST_WAIT_R  = 3'd3,
    ST_SKIP_R  = 3'd4,
    ST_SHIFT_R = 3'd5,
    ST_WAIT_L  = 3'd6
  } state_t;

  // Input synchronizers and bit-clock edge detection
  logic [2:0] r_bclk_sync;
  logic [1:0] r_lrck_sync;
  logic [1:0] r_dat_sync;
  logic       r_lrck_prev;
  logic       r_lrck_primed;

  logic w_bclk_rise;
  logic w_lrck;
  logic w_dat;
  logic w_lrck_edge;
  logic w_edge_left;
  logic w_edge_right;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_bclk_sync   <= '0;
      r_lrck_sync   <= '0;
      r_dat_sync    <= '0;
      r_lrck_prev   <= 1'b0;
      r_lrck_primed <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], adc_bclk};
      r_lrck_sync <= {r_lrck_sync[0], adc_lrck};
      r_dat_sync  <= {r_dat_sync[0], adc_dat};
      if (w_bclk_rise) begin
        r_lrck_prev   <= w_lrck;
        r_lrck_primed <= 1'b1;
      end
    end
  end

  assign w_bclk_rise  = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_lrck       = r_lrck_sync[1];
  assign w_dat        = r_dat_sync[1];
  // The first bit clock after reset only primes the LRCK history.
  assign w_lrck_edge  = r_lrck_primed & (w_lrck != r_lrck_prev);
  assign w_edge_left  = w_lrck_edge & (w_lrck == c_left_lvl);
  assign w_edge_right = w_lrck_edge & (w_lrck != c_left_lvl);

  // Frame state machine
  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] w_shift_in;
  logic [c_cnt_w-1:0]    r_bit_cnt;
  logic [c_cnt_w-1:0]    w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] w_left_nxt;
  logic                  w_last;
  logic                  w_push;
  logic                  w_frame_err_evt;
  logic [c_pair_w-1:0]   w_push_data;

  assign w_shift_in  = {r_shift[DATA_WIDTH-2:0], w_dat};
  assign w_last      = (r_bit_cnt == c_cnt_last);
  assign w_push_data = {r_left, w_shift_in};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= ST_SYNC;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_left    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_left    <= w_left_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_bit_cnt;
    w_left_nxt      = r_left;
    w_push          = 1'b0;
    w_frame_err_evt = 1'b0;
    if (w_bclk_rise) begin
      case (r_state)
        ST_SYNC, ST_WAIT_L: begin
          if (w_edge_left) begin
            if (c_i2s) begin
              w_state_nxt = ST_SKIP_L;
            end else begin
              w_shift_nxt = w_shift_in;
              w_cnt_nxt   = c_cnt_one;
              w_state_nxt = ST_SHIFT_L;
            end
          end
        end
        ST_WAIT_R: begin
          if (w_edge_right) begin
            if (c_i2s) begin
              w_state_nxt = ST_SKIP_R;
            end else begin
              w_shift_nxt = w_shift_in;
              w_cnt_nxt   = c_cnt_one;
              w_state_nxt = ST_SHIFT_R;
            end
          end
        end
        // The edge-cycle bit was the I2S delay slot; this bit is the MSB.
        ST_SKIP_L, ST_SKIP_R: begin
          if (w_lrck_edge) begin
            w_frame_err_evt = 1'b1;
            w_state_nxt     = ST_SYNC;
          end else begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = c_cnt_one;
            w_state_nxt = (r_state == ST_SKIP_L) ? ST_SHIFT_L : ST_SHIFT_R;
          end
        end
        // In I2S the LSB may legally share its BCLK with the next LRCK edge.
        ST_SHIFT_L: begin
          if (w_lrck_edge && !(c_i2s && w_last)) begin
            w_frame_err_evt = 1'b1;
            w_state_nxt     = ST_SYNC;
          end else begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_bit_cnt + c_cnt_one;
            if (w_last) begin
              w_left_nxt  = w_shift_in;
              w_state_nxt = w_lrck_edge ? ST_SKIP_R : ST_WAIT_R;
            end
          end
        end
        ST_SHIFT_R: begin
          if (w_lrck_edge && !(c_i2s && w_last)) begin
            w_frame_err_evt = 1'b1;
            w_state_nxt     = ST_SYNC;
          end else begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_bit_cnt + c_cnt_one;
            if (w_last) begin
              w_push      = 1'b1;
              w_state_nxt = w_lrck_edge ? ST_SKIP_L : ST_WAIT_L;
            end
          end
        end
        default: w_state_nxt = ST_SYNC;
      endcase
    end
  end

  // Stereo-pair FIFO with a registered head
  logic [c_pair_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_lvl_w-1:0]  r_count;
  logic [c_pair_w-1:0] r_head;
  logic                r_valid;
  logic                r_overflow;
  logic                r_frame_error;

  logic                w_pop;
  logic                w_full;
  logic                w_push_ok;
  logic                w_ovf_evt;
  logic                w_drained;
  logic [c_lvl_w-1:0]  w_count_nxt;
  logic [c_ptr_w-1:0]  w_rd_nxt;
  logic [c_pair_w-1:0] w_head_nxt;

  assign w_pop     = r_valid & sample_ready;
  assign w_full    = (r_count == c_lvl_full);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_evt = w_push & w_full & ~w_pop;
  assign w_rd_nxt  = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
  assign w_drained = w_pop ? (r_count == c_lvl_one) : (r_count == '0);
  assign w_head_nxt = (w_push_ok && w_drained) ? w_push_data : r_mem[w_rd_nxt];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + c_lvl_one;
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - c_lvl_one;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_head        <= '0;
      r_valid       <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      r_rd_ptr      <= w_rd_nxt;
      r_count       <= w_count_nxt;
      r_valid       <= (w_count_nxt != '0);
      r_head        <= w_head_nxt;
      r_overflow    <= w_ovf_evt | (r_overflow & ~clear_status);
      r_frame_error <= w_frame_err_evt | (r_frame_error & ~clear_status);
    end
  end

  assign sample_left  = r_head[c_pair_w-1:DATA_WIDTH];
  assign sample_right = r_head[DATA_WIDTH-1:0];
  assign sample_valid = r_valid;
  assign overflow     = r_overflow;
  assign frame_error  = r_frame_error;

endmodule

`default_nettype wire
